// File: rtl/pe_pkg.sv
// Shared definitions for the EKF systolic MAC array.
// Op codes, default widths and the saturation helper.
package pe_pkg;

  localparam logic PE_OP_MAC = 1'b0;
  localparam logic PE_OP_SUB = 1'b1;

  localparam int PE_DW    = 32;
  localparam int PE_FRAC  = 19;
  localparam int PE_GUARD = 8;

  // Working width of the clamp helper; callers sign-extend into it.
  localparam int SAT_XW = 64;

  // Clamp a signed value to the range of a dw-bit signed word.
  function automatic logic signed [SAT_XW-1:0] sat_dw(
    input logic signed [SAT_XW-1:0] x,
    input int                       dw
  );
    logic signed [SAT_XW-1:0] hi;
    logic signed [SAT_XW-1:0] lo;
    hi = $signed((SAT_XW'(1) << (dw - 1)) - SAT_XW'(1));
    lo = ~hi;
    if (x > hi)
      sat_dw = hi;
    else if (x < lo)
      sat_dw = lo;
    else
      sat_dw = x;
  endfunction

endpackage

// File: rtl/pe_fxp_mul.sv
// Registered signed fixed-point multiply.
// Rescales the held product back to FRAC_BIT with optional rounding.
module pe_fxp_mul #(
  parameter int DW       = 32,
  parameter int FRAC_BIT = 19,
  parameter int ACC_W    = 40,
  parameter int ROUND    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] prod
);

  localparam int PW = 2 * DW;
  localparam logic [PW-1:0] RND =
    (ROUND != 0) ? (PW'(1) << (FRAC_BIT - 1)) : '0;

  logic signed [PW-1:0] product_r;
  logic signed [PW-1:0] rounded;

  // Full-width product, captured only for valid operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      product_r <= '0;
    else if (en)
      product_r <= PW'($signed(a)) * PW'($signed(b));
  end

  assign rounded = product_r + $signed(RND);
  assign prod    = ACC_W'(rounded >>> FRAC_BIT);

endmodule

// File: rtl/pe_mac_sat.sv
// Systolic MAC/MSUB processing element with saturation.
// Results flow west; a one-entry hold absorbs collisions.
module pe_mac_sat
  import pe_pkg::*;
#(
  parameter int DW       = PE_DW,
  parameter int FRAC_BIT = PE_FRAC,
  parameter int GUARD    = PE_GUARD,
  parameter int ROUND    = 1
) (
  input  logic          clk,
  input  logic          sys_rst_n,
  input  logic [1:0]    PE_mode,
  input  logic          op_sub,
  input  logic          cal_en_N,
  input  logic          cal_done_N,
  input  logic [DW-1:0] v_data_N,
  input  logic [DW-1:0] h_data_W,
  output logic          cal_en_S,
  output logic          cal_done_S,
  output logic [DW-1:0] v_data_S,
  output logic [DW-1:0] h_data_E,
  input  logic          mulres_val_E,
  input  logic [DW-1:0] mulres_E,
  output logic          mulres_val_W,
  output logic [DW-1:0] mulres_W,
  output logic          sat_flag,
  output logic          ovf_err
);

  localparam int ACC_W = DW + GUARD;

  logic [1:0]              mode_q;
  logic                    mode_chg;
  logic                    first_pend;
  logic                    p_vld;
  logic                    p_done;
  logic                    p_sub;
  logic                    p_first;
  logic [ACC_W-1:0]        prod_raw;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic signed [SAT_XW-1:0] sum_x;
  logic signed [SAT_XW-1:0] sat_x;
  logic                    clamp;
  logic [DW-1:0]           res;
  logic                    local_rdy;
  logic                    hold_full;
  logic [DW-1:0]           hold;

  pe_fxp_mul #(
    .DW       (DW),
    .FRAC_BIT (FRAC_BIT),
    .ACC_W    (ACC_W),
    .ROUND    (ROUND)
  ) u_mul (
    .clk   (clk),
    .rst_n (sys_rst_n),
    .en    (cal_en_N),
    .a     (h_data_W),
    .b     (v_data_N),
    .prod  (prod_raw)
  );

  assign prod     = $signed(prod_raw);
  assign mode_chg = (PE_mode != mode_q);

  // Stage-2 arithmetic: accumulate or restart, then clamp.
  always_comb begin
    base  = p_first ? '0 : acc;
    sum   = (p_sub == PE_OP_SUB) ? base - prod : base + prod;
    sum_x = {{(SAT_XW-ACC_W){sum[ACC_W-1]}}, sum};
    sat_x = sat_dw(sum_x, DW);
    clamp = (sat_x != sum_x);
    res   = DW'(sat_x);
    local_rdy = p_vld & p_done;
  end

  // Stage-1 control; a restart is owed after done or mode change.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q     <= '0;
      first_pend <= 1'b1;
      p_vld      <= 1'b0;
      p_done     <= 1'b0;
      p_sub      <= 1'b0;
      p_first    <= 1'b0;
    end else begin
      mode_q  <= PE_mode;
      p_vld   <= cal_en_N;
      p_done  <= cal_en_N & cal_done_N;
      p_sub   <= op_sub;
      p_first <= first_pend | mode_chg;
      if (cal_en_N)
        first_pend <= cal_done_N;
      else if (mode_chg)
        first_pend <= 1'b1;
    end
  end

  // Systolic forwarding of operands and their strobes.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cal_en_S   <= 1'b0;
      cal_done_S <= 1'b0;
      v_data_S   <= '0;
      h_data_E   <= '0;
    end else begin
      cal_en_S   <= cal_en_N;
      cal_done_S <= cal_done_N;
      v_data_S   <= cal_en_N ? v_data_N : '0;
      h_data_E   <= cal_en_N ? h_data_W : '0;
    end
  end

  // Accumulator; cleared as a result leaves it.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else if (p_vld) begin
      acc <= p_done ? '0 : sum;
      if (p_done && clamp)
        sat_flag <= 1'b1;
    end
  end

  // Westward result mux: east traffic first, then hold, then local.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mulres_val_W <= 1'b0;
      mulres_W     <= '0;
      hold_full    <= 1'b0;
      hold         <= '0;
      ovf_err      <= 1'b0;
    end else begin
      mulres_val_W <= 1'b0;
      mulres_W     <= '0;
      if (mulres_val_E) begin
        mulres_val_W <= 1'b1;
        mulres_W     <= mulres_E;
        if (local_rdy) begin
          if (hold_full) begin
            ovf_err <= 1'b1;
          end else begin
            hold_full <= 1'b1;
            hold      <= res;
          end
        end
      end else if (hold_full) begin
        mulres_val_W <= 1'b1;
        mulres_W     <= hold;
        if (local_rdy)
          hold <= res;
        else
          hold_full <= 1'b0;
      end else if (local_rdy) begin
        mulres_val_W <= 1'b1;
        mulres_W     <= res;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_sat.sv
// Directed bench for pe_mac_sat (DW=32, FRAC_BIT=19, GUARD=8).
// Q19 constants: 1.0 = 0x0008_0000.
module tb_pe_mac_sat;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  PE_mode;
  logic        op_sub;
  logic        cal_en_N;
  logic        cal_done_N;
  logic [31:0] v_data_N;
  logic [31:0] h_data_W;
  logic        cal_en_S;
  logic        cal_done_S;
  logic [31:0] v_data_S;
  logic [31:0] h_data_E;
  logic        mulres_val_E;
  logic [31:0] mulres_E;
  logic        mulres_val_W;
  logic [31:0] mulres_W;
  logic        sat_flag;
  logic        ovf_err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] Q1_0  = 32'h0008_0000;
  localparam logic [31:0] Q1_5  = 32'h000C_0000;
  localparam logic [31:0] Q2_0  = 32'h0010_0000;
  localparam logic [31:0] Q3_0  = 32'h0018_0000;
  localparam logic [31:0] Q4_0  = 32'h0020_0000;
  localparam logic [31:0] Q0_25 = 32'h0002_0000;
  localparam logic [31:0] Q0_5  = 32'h0004_0000;
  localparam logic [31:0] QM0_5 = 32'hFFFC_0000;
  localparam logic [31:0] Q2047 = 32'h3FF8_0000;
  localparam logic [31:0] QM2047 = 32'hC008_0000;

  pe_mac_sat dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .PE_mode      (PE_mode),
    .op_sub       (op_sub),
    .cal_en_N     (cal_en_N),
    .cal_done_N   (cal_done_N),
    .v_data_N     (v_data_N),
    .h_data_W     (h_data_W),
    .cal_en_S     (cal_en_S),
    .cal_done_S   (cal_done_S),
    .v_data_S     (v_data_S),
    .h_data_E     (h_data_E),
    .mulres_val_E (mulres_val_E),
    .mulres_E     (mulres_E),
    .mulres_val_W (mulres_val_W),
    .mulres_W     (mulres_W),
    .sat_flag     (sat_flag),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic done,
                       input logic sub,
                       input logic [31:0] h,
                       input logic [31:0] v);
    cal_en_N   = en;
    cal_done_N = done;
    op_sub     = sub;
    h_data_W   = h;
    v_data_N   = v;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_out(input string tag,
                         input logic vld,
                         input logic [31:0] val);
    chk({tag, "_vld"}, 32'(mulres_val_W), 32'(vld));
    chk({tag, "_dat"}, mulres_W, val);
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    PE_mode      = 2'd0;
    op_sub       = 1'b0;
    cal_en_N     = 1'b0;
    cal_done_N   = 1'b0;
    v_data_N     = '0;
    h_data_W     = '0;
    mulres_val_E = 1'b0;
    mulres_E     = '0;
    #1;
    chk("rst_val_w", 32'(mulres_val_W), 32'd0);
    chk("rst_en_s", 32'(cal_en_S), 32'd0);
    chk("rst_v_s", v_data_S, 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // T1: 1.5*2 + 2*0.25 - 0.5*4 = 1.5, with a pause and stray done
    drive(1'b1, 1'b0, 1'b0, Q1_5, Q2_0);
    chk("t1_v_s", v_data_S, Q2_0);
    chk("t1_h_e", h_data_E, Q1_5);
    chk("t1_en_s", 32'(cal_en_S), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h55, 32'h66);
    chk("t1_v_s_gate", v_data_S, 32'd0);
    chk("t1_h_e_gate", h_data_E, 32'd0);
    chk("t1_done_s", 32'(cal_done_S), 32'd1);
    drive(1'b1, 1'b0, 1'b0, Q2_0, Q0_25);
    drive(1'b1, 1'b1, 1'b0, QM0_5, Q4_0);
    chk_out("t1_t", 1'b0, 32'h0);
    idle();
    chk_out("t1_t2", 1'b1, Q1_5);
    idle();
    chk_out("t1_t3", 1'b0, 32'h0);

    // T2: MSUB -(1*3) - (2*1) = -5.0
    drive(1'b1, 1'b0, 1'b1, Q1_0, Q3_0);
    drive(1'b1, 1'b1, 1'b1, Q2_0, Q1_0);
    idle();
    chk_out("t2", 1'b1, 32'hFFD8_0000);

    // Rounding: 2^-19 * 0.5 rounds up to 1 LSB; negative half goes to 0
    drive(1'b1, 1'b1, 1'b0, 32'h1, Q0_5);
    idle();
    chk_out("rnd_pos", 1'b1, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, Q0_5);
    idle();
    chk_out("rnd_neg", 1'b1, 32'h0);

    // T3: saturation both ways
    chk("t3_sat_pre", 32'(sat_flag), 32'd0);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'(i == 7), 1'b0, Q2047, Q1_0);
    idle();
    chk_out("t3_pos", 1'b1, 32'h7FFF_FFFF);
    chk("t3_sat", 32'(sat_flag), 32'd1);
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'(i == 7), 1'b0, QM2047, Q1_0);
    idle();
    chk_out("t3_neg", 1'b1, 32'h8000_0000);

    // T4: one-cycle collision
    drive(1'b1, 1'b1, 1'b0, Q1_0, Q1_0);
    mulres_val_E = 1'b1;
    mulres_E     = 32'h0000_1234;
    idle();
    chk_out("t4_e", 1'b1, 32'h0000_1234);
    mulres_val_E = 1'b0;
    mulres_E     = 32'hDEAD_BEEF;
    idle();
    chk_out("t4_loc", 1'b1, Q1_0);
    idle();
    chk_out("t4_end", 1'b0, 32'h0);

    // T4 variant: east busy for three cycles
    drive(1'b1, 1'b1, 1'b0, Q1_5, Q2_0);
    mulres_val_E = 1'b1;
    mulres_E     = 32'h0000_AAAA;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_out("t4v_e", 1'b1, 32'h0000_AAAA);
    end
    mulres_val_E = 1'b0;
    idle();
    chk_out("t4v_loc", 1'b1, Q3_0);
    chk("t4v_ovf", 32'(ovf_err), 32'd0);
    idle();
    chk_out("t4v_end", 1'b0, 32'h0);

    // T5: hold full, second local result dropped
    drive(1'b1, 1'b1, 1'b0, Q1_0, Q1_0);
    mulres_val_E = 1'b1;
    mulres_E     = 32'h0000_1111;
    drive(1'b1, 1'b1, 1'b0, Q2_0, Q1_0);
    chk_out("t5_e1", 1'b1, 32'h0000_1111);
    mulres_E = 32'h0000_2222;
    idle();
    chk_out("t5_e2", 1'b1, 32'h0000_2222);
    chk("t5_ovf", 32'(ovf_err), 32'd1);
    mulres_val_E = 1'b0;
    idle();
    chk_out("t5_hold", 1'b1, Q1_0);
    idle();
    chk_out("t5_end", 1'b0, 32'h0);
    chk("t5_ovf_sticky", 32'(ovf_err), 32'd1);

    // T6: mode change discards the stale partial sum
    drive(1'b1, 1'b0, 1'b0, Q1_0, Q1_0);
    PE_mode = 2'd1;
    drive(1'b1, 1'b1, 1'b0, Q2_0, Q1_0);
    idle();
    chk_out("t6", 1'b1, Q2_0);

    // Reset mid-operation with a result in flight
    drive(1'b1, 1'b0, 1'b0, Q1_0, Q1_0);
    drive(1'b1, 1'b1, 1'b0, Q1_0, Q1_0);
    cal_en_N   = 1'b0;
    cal_done_N = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_en_s", 32'(cal_en_S), 32'd0);
    chk("mrst_v_s", v_data_S, 32'd0);
    chk("mrst_sat", 32'(sat_flag), 32'd0);
    chk("mrst_ovf", 32'(ovf_err), 32'd0);
    chk_out("mrst", 1'b0, 32'h0);
    #3;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_out("mrst_post", 1'b0, 32'h0);
    end
    drive(1'b1, 1'b1, 1'b0, Q2_0, Q1_0);
    idle();
    chk_out("mrst_fresh", 1'b1, Q2_0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
